// File: rtl/aes_core_arbiter_pkg.sv
// Shared types for the AES core arbiter: FSM encoding, cipher op / key length
// enums and the round-robin pointer advance helper.
package aes_core_arbiter_pkg;

    typedef enum logic [2:0] {
        ARB_IDLE  = 3'd0,
        ARB_CLEAR = 3'd1,
        ARB_ISSUE = 3'd2,
        ARB_WAIT  = 3'd3,
        ARB_RESP  = 3'd4
    } arb_state_e;

    typedef enum logic {
        CIPH_FWD = 1'b0,
        CIPH_INV = 1'b1
    } ciph_op_e;

    typedef enum logic [2:0] {
        AES_128 = 3'b001,
        AES_192 = 3'b010,
        AES_256 = 3'b100
    } key_len_e;

    localparam int OwnerW = 2;
    localparam int StateW = 128;
    localparam int KeyW   = 256;

    function automatic logic [OwnerW-1:0] rr_next(input logic [OwnerW-1:0] cur, input int n);
        if (int'(cur) >= n - 1) return '0;
        return cur + OwnerW'(1);
    endfunction

endpackage

// File: rtl/aes_core_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first set request at or after ptr_i,
// wrapping to the lowest set request when none lies above the pointer.
module aes_rr_arbiter #(
    parameter int N    = 2,
    parameter int IdxW = 2
) (
    input  logic [N-1:0]    req_i,
    input  logic [IdxW-1:0] ptr_i,
    output logic [N-1:0]    gnt_o,
    output logic [IdxW-1:0] idx_o,
    output logic            valid_o
);

    logic [N-1:0] mask;
    logic [N-1:0] req_hi;
    logic [N-1:0] sel;

    always_comb begin
        mask = '0;
        for (int c = 0; c < N; c++) begin
            mask[c] = (c >= int'(ptr_i));
        end
        req_hi = req_i & mask;
        sel    = (|req_hi) ? req_hi : req_i;
        gnt_o  = '0;
        idx_o  = '0;
        // Descending scan so the lowest set bit of sel wins.
        for (int c = N - 1; c >= 0; c--) begin
            if (sel[c]) begin
                gnt_o    = '0;
                gnt_o[c] = 1'b1;
                idx_o    = IdxW'(c);
            end
        end
    end

    assign valid_o = |req_i;

endmodule

// File: rtl/aes_core_arbiter.sv
// Shares one AES cipher core between NumReq requesters, round-robin, with a
// key-clear handshake whenever ownership moves to a different requester.
module aes_core_arbiter
    import aes_core_arbiter_pkg::*;
#(
    parameter int NumReq        = 2,
    parameter bit ClearOnSwitch = 1'b1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [NumReq-1:0]     req_valid_i,
    output logic [NumReq-1:0]     req_ready_o,
    input  logic [NumReq-1:0]     req_op_i,
    input  logic [3*NumReq-1:0]   req_key_len_i,
    input  logic [128*NumReq-1:0] req_state_i,
    input  logic [256*NumReq-1:0] req_key_i,
    output logic [NumReq-1:0]     rsp_valid_o,
    input  logic [NumReq-1:0]     rsp_ready_i,
    output logic [127:0]          rsp_data_o,
    output logic                  core_in_valid_o,
    input  logic                  core_in_ready_i,
    output logic                  core_start_o,
    output logic                  core_key_clear_o,
    output logic                  core_op_o,
    output logic [2:0]            core_key_len_o,
    output logic [127:0]          core_state_o,
    output logic [255:0]          core_key_o,
    input  logic                  core_out_valid_i,
    output logic                  core_out_ready_o,
    input  logic [127:0]          core_data_i,
    output logic [1:0]            owner_o,
    output logic                  busy_o
);

    arb_state_e        state_q, state_d;
    logic [OwnerW-1:0] owner_q, owner_d;
    logic [OwnerW-1:0] ptr_q, ptr_d;
    logic [OwnerW-1:0] last_owner_q, last_owner_d;
    logic              last_vld_q, last_vld_d;
    ciph_op_e          op_q, op_d;
    logic [2:0]        key_len_q, key_len_d;
    logic [StateW-1:0] state_init_q, state_init_d;
    logic [KeyW-1:0]   key_q, key_d;
    logic [NumReq-1:0] rsp_valid_q, rsp_valid_d;
    logic [127:0]      rsp_data_q, rsp_data_d;

    logic [NumReq-1:0] gnt_oh;
    logic [OwnerW-1:0] gnt_idx;
    logic              gnt_vld;
    logic              need_clear;
    logic              own_rsp_ready;
    logic [NumReq-1:0] req_ready;
    logic              core_out_ready;
    logic              op_sel;
    logic [2:0]        key_len_sel;
    logic [StateW-1:0] state_sel;
    logic [KeyW-1:0]   key_sel;

    aes_rr_arbiter #(
        .N    (NumReq),
        .IdxW (OwnerW)
    ) u_rr_arbiter (
        .req_i   (req_valid_i),
        .ptr_i   (ptr_q),
        .gnt_o   (gnt_oh),
        .idx_o   (gnt_idx),
        .valid_o (gnt_vld)
    );

    // Granted requester's payload, and the current owner's response ready.
    always_comb begin
        op_sel        = 1'b0;
        key_len_sel   = '0;
        state_sel     = '0;
        key_sel       = '0;
        own_rsp_ready = 1'b0;
        for (int i = 0; i < NumReq; i++) begin
            if (gnt_oh[i]) begin
                op_sel      = req_op_i[i];
                key_len_sel = req_key_len_i[3*i +: 3];
                state_sel   = req_state_i[StateW*i +: StateW];
                key_sel     = req_key_i[KeyW*i +: KeyW];
            end
            if (owner_q == OwnerW'(i)) begin
                own_rsp_ready = rsp_ready_i[i];
            end
        end
    end

    assign need_clear = ClearOnSwitch && (!last_vld_q || (gnt_idx != last_owner_q));

    always_comb begin
        state_d        = state_q;
        owner_d        = owner_q;
        ptr_d          = ptr_q;
        last_owner_d   = last_owner_q;
        last_vld_d     = last_vld_q;
        op_d           = op_q;
        key_len_d      = key_len_q;
        state_init_d   = state_init_q;
        key_d          = key_q;
        rsp_valid_d    = rsp_valid_q;
        rsp_data_d     = rsp_data_q;
        req_ready      = '0;
        core_out_ready = 1'b0;

        unique case (state_q)
            ARB_IDLE: begin
                if (gnt_vld) begin
                    req_ready    = gnt_oh;
                    owner_d      = gnt_idx;
                    op_d         = ciph_op_e'(op_sel);
                    key_len_d    = key_len_sel;
                    state_init_d = state_sel;
                    key_d        = key_sel;
                    state_d      = need_clear ? ARB_CLEAR : ARB_ISSUE;
                end
            end
            ARB_CLEAR: begin
                if (core_in_ready_i) state_d = ARB_ISSUE;
            end
            ARB_ISSUE: begin
                if (core_in_ready_i) state_d = ARB_WAIT;
            end
            ARB_WAIT: begin
                if (core_out_valid_i) begin
                    rsp_data_d = core_data_i;
                    for (int i = 0; i < NumReq; i++) begin
                        rsp_valid_d[i] = (owner_q == OwnerW'(i));
                    end
                    state_d = ARB_RESP;
                end
            end
            ARB_RESP: begin
                // Core keeps its result until the owner takes ours.
                core_out_ready = own_rsp_ready;
                if (own_rsp_ready) begin
                    rsp_valid_d  = '0;
                    rsp_data_d   = '0;
                    state_init_d = '0;
                    key_d        = '0;
                    last_owner_d = owner_q;
                    last_vld_d   = 1'b1;
                    ptr_d        = rr_next(owner_q, NumReq);
                    state_d      = ARB_IDLE;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= ARB_IDLE;
            owner_q      <= '0;
            ptr_q        <= '0;
            last_owner_q <= '0;
            last_vld_q   <= 1'b0;
            op_q         <= CIPH_FWD;
            key_len_q    <= '0;
            state_init_q <= '0;
            key_q        <= '0;
            rsp_valid_q  <= '0;
            rsp_data_q   <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            ptr_q        <= ptr_d;
            last_owner_q <= last_owner_d;
            last_vld_q   <= last_vld_d;
            op_q         <= op_d;
            key_len_q    <= key_len_d;
            state_init_q <= state_init_d;
            key_q        <= key_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_data_q   <= rsp_data_d;
        end
    end

    logic issue;
    assign issue = (state_q == ARB_ISSUE);

    // The grant is combinational in IDLE, so mask it while reset is held.
    assign req_ready_o      = rst_i ? '0 : req_ready;
    assign core_out_ready_o = core_out_ready;
    assign core_in_valid_o  = (state_q == ARB_CLEAR) || issue;
    assign core_key_clear_o = (state_q == ARB_CLEAR);
    assign core_start_o     = issue;
    // Payload only reaches the core while issuing; zero otherwise.
    assign core_op_o        = issue && (op_q == CIPH_INV);
    assign core_key_len_o   = issue ? key_len_q : '0;
    assign core_state_o     = issue ? state_init_q : '0;
    assign core_key_o       = issue ? key_q : '0;
    assign rsp_valid_o      = rsp_valid_q;
    assign rsp_data_o       = rsp_data_q;
    assign owner_o          = owner_q;
    assign busy_o           = (state_q != ARB_IDLE);

endmodule

// File: tb/tb_aes_core_arbiter.sv
// Directed bench for aes_core_arbiter (NumReq=2, ClearOnSwitch=1); the bench
// plays the cipher core and both requesters.
module tb_aes_core_arbiter;

    logic           clk_i = 1'b0;
    logic           rst_i;
    logic [1:0]     req_valid_i;
    logic [1:0]     req_ready_o;
    logic [1:0]     req_op_i;
    logic [5:0]     req_key_len_i;
    logic [255:0]   req_state_i;
    logic [511:0]   req_key_i;
    logic [1:0]     rsp_valid_o;
    logic [1:0]     rsp_ready_i;
    logic [127:0]   rsp_data_o;
    logic           core_in_valid_o;
    logic           core_in_ready_i;
    logic           core_start_o;
    logic           core_key_clear_o;
    logic           core_op_o;
    logic [2:0]     core_key_len_o;
    logic [127:0]   core_state_o;
    logic [255:0]   core_key_o;
    logic           core_out_valid_i;
    logic           core_out_ready_o;
    logic [127:0]   core_data_i;
    logic [1:0]     owner_o;
    logic           busy_o;

    int n_assert = 0;
    int n_fail   = 0;
    int clr_cnt  = 0;

    logic [255:0] key_tbl [2];
    logic [127:0] st_tbl  [2];
    logic         op_tbl  [2];
    logic [2:0]   kl_tbl  [2];

    localparam logic [127:0] FipsCt = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    always #5 clk_i = ~clk_i;

    aes_core_arbiter #(
        .NumReq        (2),
        .ClearOnSwitch (1'b1)
    ) dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .req_valid_i      (req_valid_i),
        .req_ready_o      (req_ready_o),
        .req_op_i         (req_op_i),
        .req_key_len_i    (req_key_len_i),
        .req_state_i      (req_state_i),
        .req_key_i        (req_key_i),
        .rsp_valid_o      (rsp_valid_o),
        .rsp_ready_i      (rsp_ready_i),
        .rsp_data_o       (rsp_data_o),
        .core_in_valid_o  (core_in_valid_o),
        .core_in_ready_i  (core_in_ready_i),
        .core_start_o     (core_start_o),
        .core_key_clear_o (core_key_clear_o),
        .core_op_o        (core_op_o),
        .core_key_len_o   (core_key_len_o),
        .core_state_o     (core_state_o),
        .core_key_o       (core_key_o),
        .core_out_valid_i (core_out_valid_i),
        .core_out_ready_o (core_out_ready_o),
        .core_data_i      (core_data_i),
        .owner_o          (owner_o),
        .busy_o           (busy_o)
    );

    // Count completed key-clear handshakes on the core interface.
    always @(posedge clk_i) begin
        if (core_in_valid_o && core_key_clear_o && core_in_ready_i) clr_cnt <= clr_cnt + 1;
    end

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One full transaction; entered and left at a negedge with the DUT in IDLE.
    task automatic txn(input string nm, input logic [1:0] vld, input logic [1:0] hold,
                       input int r, input bit exp_clr, input logic [127:0] res,
                       input int in_stall, input int rsp_stall);
        logic [1:0] oh;
        oh = 2'b01 << r;
        req_valid_i = vld;
        #1;
        chk({nm, "_grant"}, 256'(req_ready_o), 256'(oh));
        @(negedge clk_i);
        req_valid_i = hold;
        #1;
        chk({nm, "_owner"}, 256'(owner_o), 256'(r));
        chk({nm, "_ready_pulse"}, 256'(req_ready_o), 256'(0));
        chk({nm, "_clear"}, 256'({core_key_clear_o, core_in_valid_o}), 256'({exp_clr, 1'b1}));
        if (exp_clr) begin
            chk({nm, "_clr_nostart"}, 256'(core_start_o), 256'(0));
            core_in_ready_i = 1'b1;
            @(negedge clk_i);
        end
        core_in_ready_i = 1'b0;
        #1;
        chk({nm, "_issue_ctl"}, 256'({core_in_valid_o, core_start_o, core_key_clear_o}), 256'(3'b110));
        chk({nm, "_issue_key"}, core_key_o, key_tbl[r]);
        chk({nm, "_issue_st"}, 256'({core_op_o, core_key_len_o, core_state_o}),
            256'({op_tbl[r], kl_tbl[r], st_tbl[r]}));
        for (int s = 0; s < in_stall; s++) begin
            @(negedge clk_i);
            #1;
            chk({nm, "_stall_ctl"}, 256'({core_in_valid_o, core_start_o}), 256'(2'b11));
            chk({nm, "_stall_key"}, core_key_o, key_tbl[r]);
            chk({nm, "_stall_st"}, 256'({core_op_o, core_key_len_o, core_state_o}),
                256'({op_tbl[r], kl_tbl[r], st_tbl[r]}));
        end
        core_in_ready_i = 1'b1;
        @(negedge clk_i);
        core_in_ready_i = 1'b0;
        #1;
        chk({nm, "_wait"}, 256'({core_in_valid_o, core_start_o, busy_o, rsp_valid_o}), 256'(5'b00100));
        core_out_valid_i = 1'b1;
        core_data_i      = res;
        @(negedge clk_i);
        core_data_i = ~res;
        for (int s = 0; s < rsp_stall; s++) begin
            #1;
            chk({nm, "_hold_v"}, 256'({rsp_valid_o, core_out_ready_o, req_ready_o}), 256'({oh, 1'b0, 2'b00}));
            chk({nm, "_hold_d"}, 256'(rsp_data_o), 256'(res));
            @(negedge clk_i);
        end
        rsp_ready_i = oh;
        #1;
        chk({nm, "_rsp_v"}, 256'({rsp_valid_o, core_out_ready_o}), 256'({oh, 1'b1}));
        chk({nm, "_rsp_d"}, 256'(rsp_data_o), 256'(res));
        @(negedge clk_i);
        rsp_ready_i      = 2'b00;
        core_out_valid_i = 1'b0;
        core_data_i      = '0;
        #1;
        chk({nm, "_done"}, 256'({rsp_valid_o, busy_o, core_out_ready_o}), 256'(0));
        chk({nm, "_zero"}, 256'(rsp_data_o), 256'(0));
    endtask

    initial begin
        key_tbl[0] = {128'h0, 128'h000102030405060708090a0b0c0d0e0f};
        key_tbl[1] = 256'hfedcba98_76543210_0f1e2d3c_4b5a6978_8796a5b4_c3d2e1f0_13572468_ace0bdf9;
        st_tbl[0]  = 128'h00112233445566778899aabbccddeeff;
        st_tbl[1]  = 128'hdeadbeef_cafef00d_01234567_89abcdef;
        op_tbl[0]  = 1'b0;
        op_tbl[1]  = 1'b1;
        kl_tbl[0]  = 3'b001;
        kl_tbl[1]  = 3'b110;  // not one-hot: must pass through untouched

        rst_i            = 1'b1;
        req_valid_i      = '0;
        req_op_i         = {op_tbl[1], op_tbl[0]};
        req_key_len_i    = {kl_tbl[1], kl_tbl[0]};
        req_state_i      = {st_tbl[1], st_tbl[0]};
        req_key_i        = {key_tbl[1], key_tbl[0]};
        rsp_ready_i      = '0;
        core_in_ready_i  = 1'b0;
        core_out_valid_i = 1'b0;
        core_data_i      = '0;

        repeat (2) @(negedge clk_i);
        #1;
        chk("rst_ctl", 256'({busy_o, owner_o, rsp_valid_o, req_ready_o, core_in_valid_o, core_start_o,
                             core_key_clear_o, core_out_ready_o, core_op_o, core_key_len_o}), 256'(0));
        chk("rst_data", 256'({rsp_data_o, core_state_o}), 256'(0));
        chk("rst_key", core_key_o, 256'(0));
        @(negedge clk_i);
        rst_i = 1'b0;

        // FIPS-197 AES-128 vector from requester 0, then a repeat with no clear.
        txn("fips", 2'b01, 2'b00, 0, 1'b1, FipsCt, 0, 0);
        chk("fips_clr_cnt", 256'(clr_cnt), 256'(1));
        txn("same", 2'b01, 2'b00, 0, 1'b0, 128'h0badf00d_11111111_22222222_33333333, 0, 0);
        chk("same_clr_cnt", 256'(clr_cnt), 256'(1));

        // Requester 1 (pointer now 1) aborted by reset while waiting on the core.
        req_valid_i = 2'b10;
        #1;
        chk("rst_grant", 256'(req_ready_o), 256'(2'b10));
        @(negedge clk_i);
        req_valid_i     = 2'b00;
        core_in_ready_i = 1'b1;
        @(negedge clk_i);
        @(negedge clk_i);
        core_in_ready_i = 1'b0;
        #1;
        chk("rst_pre_wait", 256'({busy_o, core_in_valid_o, owner_o}), 256'({1'b1, 1'b0, 2'd1}));
        rst_i = 1'b1;
        @(negedge clk_i);
        #1;
        chk("rst_mid_ctl", 256'({busy_o, owner_o, rsp_valid_o, req_ready_o, core_in_valid_o, core_start_o,
                                 core_key_clear_o, core_out_ready_o, core_op_o, core_key_len_o}), 256'(0));
        chk("rst_mid_data", 256'({rsp_data_o, core_state_o}), 256'(0));
        chk("rst_mid_key", core_key_o, 256'(0));
        rst_i = 1'b0;

        // Both requesting continuously from pointer 0: 0,1,0,1, each cleared first.
        txn("alt0", 2'b11, 2'b11, 0, 1'b1, 128'ha0a0a0a0_00000000_00000000_00000001, 0, 0);
        txn("alt1", 2'b11, 2'b11, 1, 1'b1, 128'ha1a1a1a1_00000000_00000000_00000002, 0, 0);
        txn("alt2", 2'b11, 2'b11, 0, 1'b1, 128'ha2a2a2a2_00000000_00000000_00000003, 0, 0);
        txn("alt3", 2'b11, 2'b11, 1, 1'b1, 128'ha3a3a3a3_00000000_00000000_00000004, 0, 0);
        chk("alt_clr_cnt", 256'(clr_cnt), 256'(6));

        // Owner 1 again (no clear), requester 0 waits through a 20-cycle response stall.
        txn("rstall", 2'b10, 2'b11, 1, 1'b0, 128'hc0ffee00_12345678_9abcdef0_55aa55aa, 0, 20);
        chk("rstall_clr_cnt", 256'(clr_cnt), 256'(6));

        // Requester 0 finally granted (switch: clear), core stalls input 10 cycles.
        txn("istall", 2'b01, 2'b00, 0, 1'b1, 128'h0123abcd_0123abcd_0123abcd_0123abcd, 10, 0);
        chk("end_clr_cnt", 256'(clr_cnt), 256'(7));
        chk("end_idle", 256'({busy_o, req_ready_o, rsp_valid_o}), 256'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
